// File: rtl/motor_cmd_pkg.sv
// Shared FSM state encoding and err_code values for the motor command dispatcher.
// MOTOR_CMD_CHECKSUM_EN adds the CSUM state.
package motor_cmd_pkg;

`ifdef MOTOR_CMD_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_CSUM   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_COMMIT = 2'd3
  } state_e;
`endif

  typedef logic [2:0] err_code_t;

  localparam err_code_t ERR_NONE    = 3'd0;
  localparam err_code_t ERR_BADCH   = 3'd1;
  localparam err_code_t ERR_TIMEOUT = 3'd2;
  localparam err_code_t ERR_CSUM    = 3'd3;
  localparam err_code_t ERR_FULL    = 3'd4;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/motor_cmd_timeout.sv
// Inter-byte idle timer: expired is high in the TIMEOUT_CYC-th consecutive
// enabled cycle without clear; clear always wins.
module motor_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 24000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = enable && !clear && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || !enable || expired) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/motor_cmd_dispatch.sv
// UART byte-stream frame decoder dispatching command words to per-channel FIFOs.
// Optional checksum byte enabled by MOTOR_CMD_CHECKSUM_EN.
module motor_cmd_dispatch
  import motor_cmd_pkg::*;
#(
  parameter int unsigned NUM_CH      = 10,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 24000
) (
  input  logic              CLK_SE_AR,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [NUM_CH-1:0] fifo_full,
  output logic [NUM_CH-1:0] fifo_wr,
  output logic [WORD_W-1:0] fifo_data,
  output logic              frame_err,
  output logic [2:0]        err_code,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned NBYTES = WORD_W / 8;
  localparam int unsigned CH_W   = clog2_min1(NUM_CH);
  localparam int unsigned BI_W   = clog2_min1(NBYTES);

  state_e            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [BI_W-1:0]   idx_q;
  logic [WORD_W-1:0] word_q, word_d;
  err_code_t         pend_q, fin_code;
  logic [NUM_CH-1:0] fifo_wr_q, onehot;
  logic [WORD_W-1:0] fifo_data_q;
  logic              frame_err_q;
  err_code_t         err_code_q;
  logic [15:0]       frame_cnt_q;
  logic              ch_bad, tmr_en, expired;
`ifdef MOTOR_CMD_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign ch_bad = 32'(rx_data) >= NUM_CH;
  assign tmr_en = (state_q != ST_IDLE) && (state_q != ST_COMMIT);

  motor_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (CLK_SE_AR),
    .reset  (reset),
    .clear  (rx_valid),
    .enable (tmr_en),
    .expired(expired)
  );

  // fin_code resolves the drop cause at the commit point; earlier causes win.
  always_comb begin
    word_d = word_q;
    word_d[{idx_q, 3'b000} +: 8] = rx_data;
    onehot = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) onehot[i] = (ch_q == CH_W'(i));
    fin_code = pend_q;
`ifdef MOTOR_CMD_CHECKSUM_EN
    if (fin_code == ERR_NONE && rx_data != csum_q) fin_code = ERR_CSUM;
`endif
    if (fin_code == ERR_NONE && fifo_full[ch_q]) fin_code = ERR_FULL;
  end

  always_ff @(posedge CLK_SE_AR) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      pend_q      <= ERR_NONE;
      fifo_wr_q   <= '0;
      fifo_data_q <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      frame_cnt_q <= '0;
`ifdef MOTOR_CMD_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      fifo_wr_q   <= '0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (rx_valid) begin
          ch_q    <= CH_W'(rx_data);
          pend_q  <= ch_bad ? ERR_BADCH : ERR_NONE;
          idx_q   <= '0;
          state_q <= ST_DATA;
`ifdef MOTOR_CMD_CHECKSUM_EN
          csum_q  <= rx_data;
`endif
        end
        ST_DATA: if (rx_valid) begin
          word_q <= word_d;
          idx_q  <= idx_q + 1'b1;
`ifdef MOTOR_CMD_CHECKSUM_EN
          csum_q <= csum_q ^ rx_data;
          if (idx_q == BI_W'(NBYTES - 1)) state_q <= ST_CSUM;
`else
          if (idx_q == BI_W'(NBYTES - 1)) begin
            state_q <= ST_COMMIT;
            if (fin_code == ERR_NONE) begin
              fifo_wr_q   <= onehot;
              fifo_data_q <= word_d;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= fin_code;
            end
          end
`endif
        end else if (expired) begin
          state_q     <= ST_IDLE;
          frame_err_q <= 1'b1;
          err_code_q  <= (pend_q != ERR_NONE) ? pend_q : ERR_TIMEOUT;
        end
`ifdef MOTOR_CMD_CHECKSUM_EN
        ST_CSUM: if (rx_valid) begin
          state_q <= ST_COMMIT;
          if (fin_code == ERR_NONE) begin
            fifo_wr_q   <= onehot;
            fifo_data_q <= word_q;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end else begin
            frame_err_q <= 1'b1;
            err_code_q  <= fin_code;
          end
        end else if (expired) begin
          state_q     <= ST_IDLE;
          frame_err_q <= 1'b1;
          err_code_q  <= (pend_q != ERR_NONE) ? pend_q : ERR_TIMEOUT;
        end
`endif
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_wr   = fifo_wr_q;
  assign fifo_data = fifo_data_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_motor_cmd_dispatch.sv
// Randomized frame-level bench for motor_cmd_dispatch with a frame-outcome model.
// Honours MOTOR_CMD_CHECKSUM_EN the same way as the design.
module tb_motor_cmd_dispatch;

  localparam int NUM_CH = 10;
  localparam int WORD_W = 32;
  localparam int TMO    = 24000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic [NUM_CH-1:0] fifo_full = '0;
  logic [NUM_CH-1:0] fifo_wr;
  logic [WORD_W-1:0] fifo_data;
  logic              frame_err;
  logic [2:0]        err_code;
  logic [15:0]       frame_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0]       exp_data = '0;
  logic [2:0]        exp_err = '0;
  logic [15:0]       exp_cnt = '0;
  logic [NUM_CH-1:0] exp_wr;

  motor_cmd_dispatch #(
    .NUM_CH     (NUM_CH),
    .WORD_W     (WORD_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK_SE_AR(clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .fifo_full(fifo_full),
    .fifo_wr  (fifo_wr),
    .fifo_data(fifo_data),
    .frame_err(frame_err),
    .err_code (err_code),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [31:0] w,
                            input bit bad_csum, input int max_gap);
    logic [7:0] x;
    x = ch;
    send_byte(ch);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      send_byte(w[8*i +: 8]);
      x = x ^ w[8*i +: 8];
    end
`ifdef MOTOR_CMD_CHECKSUM_EN
    repeat ($urandom_range(0, max_gap)) tick();
    send_byte(bad_csum ? (x ^ 8'h01) : x);
`else
    if (bad_csum) x = 8'h00;
`endif
  endtask

  // Outcome of a complete frame: 0 commit, else the drop cause.
  function automatic logic [2:0] model_code(input logic [7:0] ch, input bit bad_csum,
                                            input logic [NUM_CH-1:0] full);
    if (ch >= NUM_CH) return 3'd1;
`ifdef MOTOR_CMD_CHECKSUM_EN
    if (bad_csum) return 3'd3;
`endif
    if (full[ch[3:0]]) return 3'd4;
    return 3'd0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      tick();
    end
    rx_valid = 1'b0;
    checks++; if (fifo_wr !== '0) begin failures++; $display("FAIL reset_wr got=%h exp=0", fifo_wr); end
    checks++; if (fifo_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", fifo_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    checks++; if (err_code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", err_code); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    logic [7:0]        vch  [4] = '{8'h03, 8'h0A, 8'h00, 8'h05};
    logic [31:0]       vw   [4] = '{32'h12345678, 32'h44332211, 32'h00000001, 32'h04030201};
    logic [NUM_CH-1:0] vfull[4] = '{10'h000, 10'h000, 10'h000, 10'h020};
    logic [2:0] code;
    for (int v = 0; v < 4; v++) begin
      fifo_full = vfull[v];
      code = model_code(vch[v], 1'b0, vfull[v]);
      send_frame(vch[v], vw[v], 1'b0, 2);
      if (code == 3'd0) begin exp_cnt++; exp_data = vw[v]; exp_wr = NUM_CH'(1) << vch[v][3:0]; end
      else begin exp_wr = '0; exp_err = code; end
      checks++; if (fifo_wr !== exp_wr) begin failures++; $display("FAIL vec%0d_wr got=%h exp=%h", v, fifo_wr, exp_wr); end
      checks++; if (fifo_data !== exp_data) begin failures++; $display("FAIL vec%0d_data got=%h exp=%h", v, fifo_data, exp_data); end
      checks++; if (frame_err !== (code != 3'd0)) begin failures++; $display("FAIL vec%0d_err got=%b exp=%b", v, frame_err, code != 3'd0); end
      checks++; if (err_code !== exp_err) begin failures++; $display("FAIL vec%0d_code got=%0d exp=%0d", v, err_code, exp_err); end
      checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL vec%0d_cnt got=%0d exp=%0d", v, frame_cnt, exp_cnt); end
      tick();
      checks++; if (fifo_wr !== '0 || frame_err !== 1'b0) begin failures++; $display("FAIL vec%0d_pulse wr=%h err=%b exp=0", v, fifo_wr, frame_err); end
    end
    fifo_full = '0;
  endtask

  task automatic test_random(input string name, input int n, input int max_gap);
    logic [7:0]        ch;
    logic [31:0]       w;
    logic [NUM_CH-1:0] full;
    logic [2:0]        code;
    bit                bad;
    for (int f = 0; f < n; f++) begin
      ch = 8'($urandom_range(0, NUM_CH + 1));
      w  = $urandom;
      for (int b = 0; b < NUM_CH; b++) full[b] = ($urandom_range(0, 3) == 0);
`ifdef MOTOR_CMD_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`else
      bad = 1'b0;
`endif
      fifo_full = full;
      code = model_code(ch, bad, full);
      send_frame(ch, w, bad, max_gap);
      if (code == 3'd0) begin exp_cnt++; exp_data = w; exp_wr = NUM_CH'(1) << ch[3:0]; end
      else begin exp_wr = '0; exp_err = code; end
      checks++; if (fifo_wr !== exp_wr) begin failures++; $display("FAIL %s%0d_wr got=%h exp=%h", name, f, fifo_wr, exp_wr); end
      checks++; if (fifo_data !== exp_data) begin failures++; $display("FAIL %s%0d_data got=%h exp=%h", name, f, fifo_data, exp_data); end
      checks++; if (frame_err !== (code != 3'd0)) begin failures++; $display("FAIL %s%0d_err got=%b exp=%b", name, f, frame_err, code != 3'd0); end
      checks++; if (err_code !== exp_err) begin failures++; $display("FAIL %s%0d_code got=%0d exp=%0d", name, f, err_code, exp_err); end
      checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL %s%0d_cnt got=%0d exp=%0d", name, f, frame_cnt, exp_cnt); end
      tick();
      checks++; if (fifo_wr !== '0 || frame_err !== 1'b0) begin failures++; $display("FAIL %s%0d_pulse wr=%h err=%b exp=0", name, f, fifo_wr, frame_err); end
      checks++; if (fifo_data !== exp_data) begin failures++; $display("FAIL %s%0d_hold got=%h exp=%h", name, f, fifo_data, exp_data); end
    end
    fifo_full = '0;
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (TMO - 1) tick();
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", frame_err); end
    tick();
    exp_err = 3'd2;
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", frame_err); end
    checks++; if (err_code !== exp_err) begin failures++; $display("FAIL tmo_code got=%0d exp=%0d", err_code, exp_err); end
    checks++; if (fifo_wr !== '0) begin failures++; $display("FAIL tmo_wr got=%h exp=0", fifo_wr); end
    tick();
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL tmo_pulse got=%b exp=0", frame_err); end
    w = $urandom;
    send_frame(8'h02, w, 1'b0, 1);
    exp_cnt++; exp_data = w;
    checks++; if (fifo_wr !== NUM_CH'(4)) begin failures++; $display("FAIL tmo_after_wr got=%h exp=004", fifo_wr); end
    checks++; if (fifo_data !== exp_data) begin failures++; $display("FAIL tmo_after_data got=%h exp=%h", fifo_data, exp_data); end
    checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL tmo_after_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    tick();
    // A byte landing exactly on the expiry cycle keeps the frame alive.
    send_byte(8'h07);
    send_byte(8'hAA);
    repeat (TMO - 1) tick();
    send_byte(8'hBB);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL tmo_tie_err got=%b exp=0", frame_err); end
    send_byte(8'hCC);
    send_byte(8'hDD);
`ifdef MOTOR_CMD_CHECKSUM_EN
    send_byte(8'h07 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
`endif
    exp_cnt++; exp_data = 32'hDDCCBBAA;
    checks++; if (fifo_wr !== NUM_CH'(8'h80)) begin failures++; $display("FAIL tmo_tie_wr got=%h exp=080", fifo_wr); end
    checks++; if (fifo_data !== exp_data) begin failures++; $display("FAIL tmo_tie_data got=%h exp=%h", fifo_data, exp_data); end
    checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL tmo_tie_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_cnt = '0; exp_data = '0; exp_err = '0;
    checks++; if (fifo_wr !== '0 || frame_err !== 1'b0) begin failures++; $display("FAIL mid_rst_pulse wr=%h err=%b exp=0", fifo_wr, frame_err); end
    checks++; if (frame_cnt !== 16'd0 || err_code !== 3'd0) begin failures++; $display("FAIL mid_rst_state cnt=%0d code=%0d exp=0", frame_cnt, err_code); end
    tick();
    send_frame(8'h04, 32'h04030201, 1'b0, 2);
    exp_cnt++; exp_data = 32'h04030201;
    checks++; if (fifo_wr !== NUM_CH'(8'h10)) begin failures++; $display("FAIL mid_rst_wr got=%h exp=010", fifo_wr); end
    checks++; if (fifo_data !== exp_data) begin failures++; $display("FAIL mid_rst_data got=%h exp=%h", fifo_data, exp_data); end
    checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL mid_rst_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    tick();
  endtask

`ifdef MOTOR_CMD_CHECKSUM_EN
  task automatic test_checksum();
    send_frame(8'h01, 32'hDDCCBBAA, 1'b0, 2);
    exp_cnt++; exp_data = 32'hDDCCBBAA;
    checks++; if (fifo_wr !== NUM_CH'(2)) begin failures++; $display("FAIL csum_ok_wr got=%h exp=002", fifo_wr); end
    checks++; if (fifo_data !== exp_data) begin failures++; $display("FAIL csum_ok_data got=%h exp=%h", fifo_data, exp_data); end
    tick();
    send_frame(8'h01, 32'hDDCCBBAA, 1'b1, 2);
    exp_err = 3'd3;
    checks++; if (fifo_wr !== '0 || frame_err !== 1'b1) begin failures++; $display("FAIL csum_bad wr=%h err=%b exp=0/1", fifo_wr, frame_err); end
    checks++; if (err_code !== exp_err) begin failures++; $display("FAIL csum_bad_code got=%0d exp=%0d", err_code, exp_err); end
    checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL csum_bad_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    tick();
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_random("rand", 40, 3);
    test_random("b2b", 12, 0);
`ifdef MOTOR_CMD_CHECKSUM_EN
    test_checksum();
`endif
    test_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_cmd_dispatch.md
MOTOR_CMD_DISPATCH -- requirements
Module: motor_cmd_dispatch

Interface
REQ-001 SHALL have parameter NUM_CH, default 10: number of motor channels.
REQ-002 SHALL have parameter WORD_W, default 32: command word width, multiple of 8, range 8..64.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 24000: maximum idle cycles between bytes inside a frame (1 ms at 24 MHz).
REQ-004 SHALL have port CLK_SE_AR  input  1: the single clock.
REQ-005 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port rx_valid  input  1: one-cycle strobe marking a received UART byte.
REQ-007 SHALL have port rx_data  input  8: the received byte, valid with rx_valid.
REQ-008 SHALL have port fifo_full  input  NUM_CH: per-channel command FIFO full flags.
REQ-009 SHALL have port fifo_wr  output  NUM_CH: one-hot write strobe.
REQ-010 SHALL have port fifo_data  output  WORD_W: command word shared by all channels.
REQ-011 SHALL have port frame_err  output  1: one-cycle pulse when a frame is dropped.
REQ-012 SHALL have port err_code  output  3: cause of the last dropped frame, held until the next drop.
REQ-013 SHALL have port frame_cnt  output  16: count of committed frames, wrapping.

Function
REQ-014 Frame format SHALL be: 1 channel byte, then WORD_W/8 data bytes, LSB first, then a checksum byte when CHECKSUM_EN is defined.
REQ-015 The FSM SHALL have states IDLE, DATA, CSUM and COMMIT; IDLE->DATA on a byte; DATA->CSUM or COMMIT after the last data byte; CSUM->COMMIT on a byte; COMMIT->IDLE unconditionally.
REQ-016 A byte arriving in IDLE SHALL be latched as the channel number; channel >= NUM_CH SHALL mark the frame bad (code 1) while the remaining bytes are still consumed so framing is kept.
REQ-017 In COMMIT, a good frame with fifo_full[ch]=0 SHALL assert fifo_wr[ch] for exactly one cycle with the assembled word on fifo_data, and SHALL increment frame_cnt.
REQ-018 The fifo_wr latency SHALL be one cycle after the rx_valid of the final byte.
REQ-019 fifo_full[ch]=1 in COMMIT SHALL drop the frame with code 4 and no write.
REQ-020 fifo_data SHALL hold its value between commits.
REQ-021 Outside IDLE, an inter-byte timer SHALL count cycles without rx_valid; reaching TIMEOUT_CYC SHALL drop the frame with code 2 and return to IDLE.
REQ-022 When rx_valid and timer expiry coincide, the byte SHALL win and the timer SHALL clear.
REQ-023 A drop SHALL pulse frame_err once per frame and load err_code; the first-detected cause SHALL take priority in the order bad channel, timeout, checksum, full.
REQ-024 err_code values SHALL be: 0 none, 1 bad channel, 2 timeout, 3 checksum, 4 FIFO full.

Reset
REQ-025 reset SHALL force: state IDLE, fifo_wr=0, fifo_data=0, frame_err=0, err_code=0, frame_cnt=0, timer=0.
REQ-026 reset asserted mid-frame SHALL discard the partial frame with no write and no frame_err.
REQ-027 rx_valid during reset SHALL be ignored.

Configuration
REQ-028 Macro MOTOR_CMD_CHECKSUM_EN, when defined, SHALL add the CSUM state; the checksum byte SHALL equal the XOR of the channel byte and all data bytes, and a mismatch SHALL drop the frame with code 3.
REQ-029 Without MOTOR_CMD_CHECKSUM_EN, the CSUM state and the XOR logic SHALL be absent, and code 3 SHALL never occur.

Structure
REQ-030 Package motor_cmd_pkg SHALL hold the FSM state encoding and the err_code constants.
REQ-031 The inter-byte timer SHALL be sub-module motor_cmd_timeout (inputs: clear, enable; output: expired).
REQ-032 Channel-index width SHALL be derived as $clog2(NUM_CH), minimum 1.

Verification
REQ-033 Checksum off, bytes 03 78 56 34 12 -> fifo_wr=0x008 for one cycle, fifo_data=0x12345678, frame_cnt=1.
REQ-034 Bytes 0A 11 22 33 44 (NUM_CH=10) -> no fifo_wr, frame_err pulse, err_code=1; the following frame 00 01 00 00 00 commits to channel 0.
REQ-035 Bytes 02 11 then 24000 idle cycles -> frame_err, err_code=2, state IDLE; a subsequent full frame commits normally.
REQ-036 fifo_full[5]=1, bytes 05 01 02 03 04 -> no write, err_code=4, frame_cnt unchanged.
REQ-037 MOTOR_CMD_CHECKSUM_EN, bytes 01 AA BB CC DD 01 -> write 0xDDCCBBAA to channel 1; the same frame with final byte 00 -> err_code=3.
REQ-038 reset pulsed after bytes 04 11 22 -> no write, no frame_err; the next frame 04 01 02 03 04 -> fifo_data=0x04030201 on channel 4.
